// File: rtl/pipe_pkg.sv
// pipe_pkg: shared defaults for pipeline stage registers and the IF/ID payload layout.
package pipe_pkg;
  localparam int PIPE_WIDTH = 64;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] pc_plus_4;
    logic [31:0] insn;
  } if_id_t;
  localparam if_id_t NOP_IF_ID = '{pc_plus_4: 32'h0, insn: NOP_INSN};
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one valid+data register; clear beats load beats drain.
module pipe_slot #(
  parameter int WIDTH = 64,
  parameter logic [WIDTH-1:0] RST_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_ld,
  input  logic             i_drain,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= RST_DATA;
    end else if (i_clr) begin
      r_valid <= 1'b0;
      r_data  <= RST_DATA;
    end else if (i_ld) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_drain)
      r_valid <= 1'b0;
  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with stall and flush.
// Define PIPE_SKID_EN for a second (skid) entry and a registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH,
  parameter logic [WIDTH-1:0] RST_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             stall,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_main_ld;
  logic [WIDTH-1:0] w_main_d;
  // a payload offered during flush is dropped even when in_ready is high
  assign w_in_fire  = in_valid & in_ready & ~flush;
  assign w_out_fire = out_valid & out_ready & ~stall;
`ifdef PIPE_SKID_EN
  logic             w_skid_valid;
  logic [WIDTH-1:0] w_skid_data;
  assign in_ready  = ~rst & ~stall & ~w_skid_valid;
  assign w_main_ld = (w_out_fire & w_skid_valid) | (w_in_fire & (~out_valid | w_out_fire));
  assign w_main_d  = w_skid_valid ? w_skid_data : in_data;
  pipe_slot #(.WIDTH(WIDTH), .RST_DATA(RST_DATA)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (flush),
    .i_ld    (w_in_fire & out_valid & ~w_out_fire),
    .i_drain (w_out_fire),
    .i_data  (in_data),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data)
  );
`else
  assign in_ready  = ~rst & ~stall & (~out_valid | out_ready);
  assign w_main_ld = w_in_fire;
  assign w_main_d  = in_data;
`endif
  pipe_slot #(.WIDTH(WIDTH), .RST_DATA(RST_DATA)) u_main (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (flush),
    .i_ld    (w_main_ld),
    .i_drain (w_out_fire),
    .i_data  (w_main_d),
    .o_valid (out_valid),
    .o_data  (out_data)
  );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed stimulus with a queue scoreboard for pipe_stage_reg.
module tb_pipe_stage_reg;
  import pipe_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        stall = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic [63:0] q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  localparam logic [63:0] NOP = 64'h0000_0000_0000_0013;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  pipe_stage_reg #(.WIDTH(64), .RST_DATA(NOP_IF_ID)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .stall     (stall),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic v, input logic [63:0] d, input logic ordy, input logic st, input logic fl);
    @(posedge clk);
    #2;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    stall     = st;
    flush     = fl;
    @(negedge clk);
  endtask

  always @(posedge rst) q.delete();

  // queue holds every accepted payload not yet consumed, so its size is the occupancy
  always @(negedge clk) begin
    logic exp_rdy;
    if (!rst) begin
      exp_rdy = !stall && (SKID ? (q.size() < 2) : (q.size() == 0 || out_ready));
      chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
      chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
      if (q.size() != 0) chk("out_data", out_data, q[0]);
      if (q.size() != 0 && out_ready && !stall) void'(q.pop_front());
      if (flush) q.delete();
      else if (in_valid && exp_rdy) q.push_back(in_data);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    repeat (2) @(negedge clk);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_data", out_data, NOP);
    chk("rst_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    // streaming
    cyc(1, 64'h1, 1, 0, 0);
    cyc(1, 64'h2, 1, 0, 0);
    chk("stream1", out_data, 64'h1);
    cyc(1, 64'h3, 1, 0, 0);
    chk("stream2", out_data, 64'h2);
    cyc(0, 64'h0, 1, 0, 0);
    chk("stream3", out_data, 64'h3);
    chk("stream3_v", {63'd0, out_valid}, 64'd1);
    cyc(0, 64'h0, 1, 0, 0);
    chk("stream_hold", out_data, 64'h3);
    chk("stream_empty", {63'd0, out_valid}, 64'd0);
    // backpressure
    cyc(1, 64'hA5, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 64'hB6, 0, 0, 0);
      chk("bp_data", out_data, 64'hA5);
      chk("bp_ready", {63'd0, in_ready}, {63'd0, SKID && i == 0});
    end
    cyc(0, 64'h0, 1, 0, 0);
    chk("bp_release", out_data, 64'hA5);
    repeat (2) cyc(0, 64'h0, 1, 0, 0);
    // stall
    cyc(1, 64'h10, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 64'h11, 1, 1, 0);
      chk("stall_data", out_data, 64'h10);
      chk("stall_valid", {63'd0, out_valid}, 64'd1);
      chk("stall_ready", {63'd0, in_ready}, 64'd0);
    end
    cyc(1, 64'h11, 1, 0, 0);
    chk("unstall_data", out_data, 64'h10);
    chk("unstall_ready", {63'd0, in_ready}, 64'd1);
    cyc(0, 64'h0, 1, 0, 0);
    chk("unstall_next", out_data, 64'h11);
    cyc(0, 64'h0, 1, 0, 0);
    // flush with stall
    cyc(1, 64'h20, 0, 0, 0);
    cyc(1, 64'h77, 0, 1, 1);
    chk("flush_pre", out_data, 64'h20);
    cyc(0, 64'h0, 1, 0, 0);
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_data", out_data, NOP);
    cyc(0, 64'h0, 1, 0, 0);
    chk("flush_no77", out_data, NOP);
    // flush drops a payload offered while in_ready is high
    cyc(1, 64'h88, 1, 0, 1);
    chk("flush_rdy", {63'd0, in_ready}, 64'd1);
    cyc(0, 64'h0, 1, 0, 0);
    chk("flush_drop_v", {63'd0, out_valid}, 64'd0);
    chk("flush_drop_d", out_data, NOP);
    // asynchronous reset mid-cycle
    cyc(1, 64'h55, 0, 0, 0);
    cyc(0, 64'h0, 0, 0, 0);
    chk("pre_rst", out_data, 64'h55);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_data", out_data, NOP);
    chk("arst_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    // continuous offer with toggling out_ready
    d = 64'h30;
    for (int i = 0; i < 10; i++) begin
      cyc(1, d, i % 2 == 0, 0, 0);
      if (in_ready) d = d + 64'h1;
    end
    repeat (4) cyc(0, 64'h0, 1, 0, 0);
    chk("drained", 64'(q.size()), 64'd0);
    chk("toggle_last", out_data, d - 64'h1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, hold (stall) and flush. It is the generic replacement for the fixed 64-bit IF/ID latch and sits between any two CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an arbitrary-width payload with one cycle of latency. An optional skid entry gives full throughput with a registered `in_ready`.

## Interface
Parameters:
- `WIDTH`, 64: payload width in bits (≥1).
- `RST_DATA`, 0: payload value after reset and after flush (bubble/NOP encoding).

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `flush`, input, 1: synchronous invalidate of the stage (branch/exception).
- `stall`, input, 1: synchronous hold (load-use); freezes the stage.
- `in_valid`, input, 1: upstream payload valid.
- `in_ready`, output, 1: stage accepts the payload this cycle.
- `in_data`, input, WIDTH: upstream payload.
- `out_valid`, output, 1: downstream payload valid.
- `out_ready`, input, 1: downstream consumes the payload this cycle.
- `out_data`, output, WIDTH: registered payload.

## Operation
- Reset: `out_valid`=0, `out_data`=RST_DATA, skid entry empty. `in_ready`=0 while `rst` is high, then follows the rules below.
- in_fire = `in_valid` & `in_ready`.
- out_fire = `out_valid` & `out_ready` & ~`stall`.
- Priority, highest first: `rst` > `flush` > `stall` > normal transfer.
- Flush: next cycle `out_valid`=0, `out_data`=RST_DATA and the skid entry is emptied. A payload offered in the flush cycle is dropped even if `in_ready`=1. Flush together with stall: flush wins.
- Stall: all contents hold, including `out_valid` and `out_data`. `in_ready`=0. Downstream `out_ready` is ignored, so no out_fire occurs.
- Normal operation without the skid entry:
  - `in_ready` = ~`stall` & (~`out_valid` | `out_ready`).
  - On in_fire, the main register loads `in_data` and `out_valid`←1.
  - On out_fire without in_fire, `out_valid`←0 and `out_data` holds its value.
- `out_data` changes only on load, flush or reset. It is never gated by `out_valid`.

## Timing
- Latency: in_fire in cycle N produces `out_valid`=1 with that data in cycle N+1.
- Without the skid entry, `in_ready` is combinational from `out_ready` and `stall`. Throughput is 1 per cycle while `out_ready`=1.
- Once `out_valid`=1, `out_valid` and `out_data` stay stable until out_fire, flush or reset.
- Asserting `rst` mid-transfer clears state immediately, without waiting for a clock edge. The payload in flight is lost.

## Configuration
- `PIPE_SKID_EN` defined: adds a second (skid) entry.
  - `in_ready` = ~skid_valid & ~`stall`, so it depends on no combinational path from `out_ready`.
  - An in_fire while main is full and not draining writes to skid.
  - On out_fire with skid full, skid moves to main in the same edge. A simultaneous in_fire is impossible because `in_ready` was 0.
  - Occupancy ranges 0..2. No payload is lost or reordered.
- `PIPE_SKID_EN` undefined: single entry, behaviour as in Operation. No skid storage is synthesised.

## Structure
- Shared package `pipe_pkg`: default `WIDTH`, the NOP instruction constant used as `RST_DATA` for IF/ID, and a typedef for the IF/ID payload (pc_plus_4, instruction).
- One sub-module, `pipe_slot`: a single valid+data register with load and clear inputs. It is instantiated once for main and once more for skid under `PIPE_SKID_EN`.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle with `out_valid`=1 → `out_valid`=0 and `out_data`=RST_DATA immediately, with no clock edge.
- Streaming: `in_valid`=1, `out_ready`=1, data 0x1,0x2,0x3 on consecutive cycles → `out_data` 0x1,0x2,0x3 one cycle later, no bubbles.
- Backpressure: `out_ready`=0 for 3 cycles with `out_valid`=1, data 0xA5 → `out_data` holds 0xA5 and no new payload is accepted. Without skid, `in_ready`=0.
- Stall: `stall`=1 for 2 cycles with `out_ready`=1 and data 0x10 held → `out_valid`=1 and `out_data`=0x10 unchanged, `in_ready`=0. Release → 0x10 consumed, next payload loads.
- Flush: `flush`=1, `stall`=1, `in_valid`=1 with data 0x77 → next cycle `out_valid`=0, `out_data`=RST_DATA, and 0x77 never appears.
- Skid (`PIPE_SKID_EN`): continuous `in_valid`, `out_ready` toggling 1,0,1,0 → every payload delivered in order, none duplicated. `in_ready` drops only with skid full.
